input_buffer: RTL

- Input-side I/O peripheral: captures raw switch and pushbutton pins and produces the `b_io_sw` and `b_io_btn` read buffers consumed by the load-data mux.
- Performs two-flop synchronisation, per-button debounce and sticky press-event capture.
- Accepts CPU stores that clear press flags (write-1-to-clear).
- Sits between the top-level pins and the LSU load path, beside the output buffer.

---
 rtl/io_map_pkg.sv | 11 +
 rtl/debounce_cell.sv | 49 ++++
 rtl/input_buffer.sv | 87 ++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// I/O region map shared by the input buffer, output buffer and load mux.
// Offsets are the low 16 address bits inside the I/O window.
package io_map_pkg;

  localparam logic [15:0] IO_SW_OFFSET  = 16'h7800;
  localparam logic [15:0] IO_BTN_OFFSET = 16'h7810;

  localparam int BTN_LEVEL_LSB = 0;
  localparam int BTN_FLAG_LSB  = 8;

endpackage

// File: rtl/debounce_cell.sv
// One pushbutton: two-flop sync, stability counter and debounced level.
// o_rise is high in the cycle whose edge takes the level 0->1.
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_s;
  logic          w_done;

  assign w_s    = ~r_sync;
  assign w_done = (w_s != r_level) && (r_cnt == CNT_MAX);
  assign o_rise = w_done & w_s;
  assign o_level = r_level;

  // Sync flops reset to the released pin level so reset never looks like a press.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_btn_n;
      r_sync <= r_meta;
      if (w_s == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= w_s;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_buffer.sv
// Switch/pushbutton input peripheral: sync, debounce, sticky press flags
// with write-1-to-clear, exposed as b_io_sw / b_io_btn read buffers.
module input_buffer
  import io_map_pkg::*;
#(
  parameter int SW_WIDTH        = 10,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [SW_WIDTH-1:0]  i_io_sw,
  input  logic [BTN_WIDTH-1:0] i_io_btn,
  input  logic                 i_st_en,
  input  logic                 i_io_valid,
  input  logic [31:0]          i_st_addr,
  input  logic [31:0]          i_st_data,
  output logic [31:0]          b_io_sw,
  output logic [31:0]          b_io_btn,
  output logic                 o_btn_event
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_dc
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (BTN_WIDTH < 1 || BTN_WIDTH > 8) begin : g_bad_btn
    $error("BTN_WIDTH must be 1..8");
  end
  if (SW_WIDTH < 1 || SW_WIDTH > 32) begin : g_bad_sw
    $error("SW_WIDTH must be 1..32");
  end

  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic [BTN_WIDTH-1:0] w_level;
  logic [BTN_WIDTH-1:0] w_rise;
  logic [BTN_WIDTH-1:0] w_clr;
  logic [BTN_WIDTH-1:0] w_flag_nxt;
  logic [BTN_WIDTH-1:0] r_flag;
  logic                 r_event;
  logic                 w_btn_wr;
  logic                 w_unused;

  for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_btn_n (i_io_btn[g]),
      .o_level (w_level[g]),
      .o_rise  (w_rise[g])
    );
  end

  assign w_btn_wr = i_st_en & i_io_valid
                  & (i_st_addr[15:0] == IO_BTN_OFFSET);
  assign w_clr = {BTN_WIDTH{w_btn_wr}}
               & i_st_data[BTN_FLAG_LSB +: BTN_WIDTH];
  // A press landing on the same edge as a clear must not be lost.
  assign w_flag_nxt = (r_flag & ~w_clr) | w_rise;
  assign w_unused = ^{i_st_addr[31:16], i_st_data};

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
      r_flag    <= '0;
      r_event   <= 1'b0;
    end else begin
      r_sw_meta <= i_io_sw;
      r_sw_sync <= r_sw_meta;
      r_flag    <= w_flag_nxt;
      r_event   <= |w_flag_nxt;
    end
  end

  assign b_io_sw     = 32'(r_sw_sync);
  assign o_btn_event = r_event;

  always_comb begin
    b_io_btn = '0;
    b_io_btn[BTN_LEVEL_LSB +: BTN_WIDTH] = w_level;
    b_io_btn[BTN_FLAG_LSB +: BTN_WIDTH]  = r_flag;
  end

endmodule
